// File: rtl/add_seq_ctrl.sv
// Byte-serial add/subtract controller.
// Operands are latched on accept, then fed one byte per cycle through a
// single 8-bit Brent-Kung adder, least significant byte first. The carry
// is kept in a register between bytes. cout and ovf describe the full-width
// result and are updated on the edge that processes the last byte.

// 8-bit Brent-Kung prefix adder with carry-in.
module bk_adder8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic [7:0] g_s;
  logic [7:0] p_s;
  logic [7:0] c_s;
  logic       g0_s;
  logic       g10_s, g32_s, g54_s, g76_s;
  logic       p32_s, p54_s, p76_s;
  logic       g30_s, g74_s, p74_s;
  logic       g70_s, g50_s, g20_s, g40_s, g60_s;

  // Prefix tree: carry-in folded into bit 0, up-sweep then down-sweep.
  always_comb begin
    g_s   = A & B;
    p_s   = A ^ B;
    g0_s  = g_s[0] | (p_s[0] & Cin);
    // up-sweep, level 1
    g10_s = g_s[1] | (p_s[1] & g0_s);
    g32_s = g_s[3] | (p_s[3] & g_s[2]);
    p32_s = p_s[3] & p_s[2];
    g54_s = g_s[5] | (p_s[5] & g_s[4]);
    p54_s = p_s[5] & p_s[4];
    g76_s = g_s[7] | (p_s[7] & g_s[6]);
    p76_s = p_s[7] & p_s[6];
    // up-sweep, level 2
    g30_s = g32_s | (p32_s & g10_s);
    g74_s = g76_s | (p76_s & g54_s);
    p74_s = p76_s & p54_s;
    // up-sweep, level 3
    g70_s = g74_s | (p74_s & g30_s);
    // down-sweep fills the remaining prefixes
    g50_s = g54_s | (p54_s & g30_s);
    g20_s = g_s[2] | (p_s[2] & g10_s);
    g40_s = g_s[4] | (p_s[4] & g30_s);
    g60_s = g_s[6] | (p_s[6] & g50_s);
    // carry into each bit
    c_s   = {g60_s, g50_s, g40_s, g30_s, g20_s, g10_s, g0_s, Cin};
    Sum   = p_s ^ c_s;
    Cout  = g70_s;
  end

endmodule

module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           op_sub_q, op_sub_d;
  logic           carry_q, carry_d;
  logic [2:0]     byte_idx_q, byte_idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [5:0]     bit_base_s;
  logic [7:0]     add_a_s;
  logic [7:0]     add_b_s;
  logic [7:0]     add_sum_s;
  logic           add_cout_s;
  logic           msb_cin_s;

  // Select the current byte of each operand; subtract uses A + ~B + 1.
  always_comb begin
    bit_base_s = {byte_idx_q, 3'b000};
    add_a_s    = a_q[bit_base_s +: 8];
    add_b_s    = b_q[bit_base_s +: 8] ^ {8{op_sub_q}};
    // carry into bit 7 of this byte, meaningful for the top byte only
    msb_cin_s  = add_sum_s[7] ^ add_a_s[7] ^ add_b_s[7];
  end

  bk_adder8 u_adder (
    .A    (add_a_s),
    .B    (add_b_s),
    .Cin  (carry_q),
    .Sum  (add_sum_s),
    .Cout (add_cout_s)
  );

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    op_sub_d   = op_sub_q;
    carry_d    = carry_q;
    byte_idx_d = byte_idx_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = a;
          b_d        = b;
          op_sub_d   = op_sub;
          byte_idx_d = 3'd0;
          carry_d    = op_sub;
          state_d    = RUN;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        sum_d[bit_base_s +: 8] = add_sum_s;
        carry_d                = add_cout_s;
        if (byte_idx_q == LAST_IDX) begin
          // index parked at 0 so it never addresses past the operand
          byte_idx_d = 3'd0;
          cout_d     = add_cout_s;
          ovf_d      = msb_cin_s ^ add_cout_s;
          state_d    = DONE;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          state_d    = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      op_sub_q   <= 1'b0;
      carry_q    <= 1'b0;
      byte_idx_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      op_sub_q   <= op_sub_d;
      carry_q    <= carry_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with NBYTES=4.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  add_seq_ctrl #(.NBYTES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, result and hold behaviour.
  // With scramble set, operands are changed right after the accept edge.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sub, input logic [31:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input bit scramble);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    @(negedge clk);
    a      = av;
    b      = bv;
    op_sub = sub;
    start  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        start = 1'b0;
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
        if (scramble) begin
          a      = 32'hFFFF_FFFF;
          b      = 32'hFFFF_FFFF;
          op_sub = ~sub;
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_latency"}, 64'(edges), 64'd5);
      check_eq({tag, "_sum"}, {32'd0, sum}, {32'd0, exp_sum});
      check_eq({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
      check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
      @(negedge clk);
      check_eq({tag, "_done_off"}, {63'd0, done}, 64'd0);
      check_eq({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
      check_eq({tag, "_sum_hold"}, {32'd0, sum}, {32'd0, exp_sum});
    end
  endtask

  int done_pos[$];
  int done_cnt;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_sum",  {32'd0, sum},  64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    check_eq("rst_ovf",  {63'd0, ovf},  64'd0);
    rst = 1'b0;

    run_op("add_small", 32'h0000_000D, 32'h0000_000B, 1'b0, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
    run_op("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Reset during the 2nd RUN cycle: outputs clear at once, no done.
    @(negedge clk);
    a      = 32'h1111_1111;
    b      = 32'h2222_2222;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_sum",  {32'd0, sum},  64'd0);
    check_eq("midrst_cout", {63'd0, cout}, 64'd0);
    check_eq("midrst_ovf",  {63'd0, ovf},  64'd0);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);

    run_op("post_rst_add", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("scramble", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);

    // start held high: accepts every 6 cycles, one done per accept.
    @(negedge clk);
    a      = 32'd3;
    b      = 32'd4;
    op_sub = 1'b0;
    start  = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_pos.push_back(i);
        check_eq("held_sum", {32'd0, sum}, 64'd7);
      end
    end
    start = 1'b0;
    check_eq("held_done_count", 64'(done_pos.size()), 64'd3);
    if (done_pos.size() == 3) begin
      check_eq("held_pos0", 64'(done_pos[0]), 64'd4);
      check_eq("held_pos1", 64'(done_pos[1]), 64'd10);
      check_eq("held_pos2", 64'(done_pos[2]), 64'd16);
    end
    repeat (3) @(negedge clk);
    check_eq("final_idle", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
